// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: two requesters on one side,
// the single data_mem port on the other.
interface dmem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_sign_mask;
  logic        a_gnt;
  logic        a_done;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_sign_mask;
  logic        b_gnt;
  logic        b_done;
  logic [31:0] b_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_sign_mask,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_sign_mask,
    output b_gnt, b_done, b_rdata,
    output mem_addr, mem_write_data, mem_memwrite,
    output mem_memread, mem_sign_mask,
    input  mem_read_data
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_sign_mask,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_sign_mask,
    input  b_gnt, b_done, b_rdata,
    input  mem_addr, mem_write_data, mem_memwrite,
    input  mem_memread, mem_sign_mask,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the data memory port: latches one
// winner's access and holds it stable for ACC_LAT cycles.
module dmem_arbiter #(
  parameter int ACC_LAT   = 2,
  parameter int FIXED_PRI = 0
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(ACC_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          owner_b;
  logic          last_b;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic [31:0]   rdata_q;
  logic          any_req;
  logic          win_b;

  assign any_req = bus.a_req | bus.b_req;

  // ties go to whoever did not win last, unless A has fixed priority
  always_comb begin
    win_b = 1'b0;
    if (bus.b_req && !bus.a_req)
      win_b = 1'b1;
    else if (bus.b_req && bus.a_req && FIXED_PRI == 0)
      win_b = ~last_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      owner_b <= 1'b0;
      last_b  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner_b <= win_b;
            last_b  <= win_b;
            cnt     <= '0;
            we_q    <= win_b ? bus.b_we : bus.a_we;
            addr_q  <= win_b ? bus.b_addr : bus.a_addr;
            wdata_q <= win_b ? bus.b_wdata : bus.a_wdata;
            mask_q  <= win_b ? bus.b_sign_mask
                             : bus.a_sign_mask;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            rdata_q <= we_q ? 32'h0 : bus.mem_read_data;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx           = state;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_sign_mask  = '0;
    bus.mem_memwrite   = 1'b0;
    bus.mem_memread    = 1'b0;
    bus.a_done         = 1'b0;
    bus.b_done         = 1'b0;
    bus.a_rdata        = '0;
    bus.b_rdata        = '0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        bus.mem_addr       = addr_q;
        bus.mem_write_data = wdata_q;
        bus.mem_sign_mask  = mask_q;
        bus.mem_memwrite   = we_q;
        bus.mem_memread    = ~we_q;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        if (owner_b) begin
          bus.b_done  = 1'b1;
          bus.b_rdata = rdata_q;
        end else begin
          bus.a_done  = 1'b1;
          bus.a_rdata = rdata_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.a_gnt = (state != IDLE) & ~owner_b;
  assign bus.b_gnt = (state != IDLE) &  owner_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and fixed-priority
// instances side by side, memory read data driven by the bench.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.ACC_LAT(2), .FIXED_PRI(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  dmem_arbiter #(.ACC_LAT(2), .FIXED_PRI(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0;
    bus0.a_wdata = 0; bus0.a_sign_mask = 0;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0;
    bus0.b_wdata = 0; bus0.b_sign_mask = 0;
    bus0.mem_read_data = 0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0;
    bus1.a_wdata = 0; bus1.a_sign_mask = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0;
    bus1.b_wdata = 0; bus1.b_sign_mask = 0;
    bus1.mem_read_data = 0;

    step();
    step();
    chk("rst_rd", 32'(bus0.mem_memread), 0);
    chk("rst_wr", 32'(bus0.mem_memwrite), 0);
    chk("rst_agnt", 32'(bus0.a_gnt), 0);
    chk("rst_bgnt", 32'(bus0.b_gnt), 0);
    chk("rst_adone", 32'(bus0.a_done), 0);
    chk("rst_addr", bus0.mem_addr, 0);
    reset = 0;
    step();

    // 1: A load alone
    bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 32'h1004;
    bus0.mem_read_data = 32'hDEADBEEF;
    step();
    chk("t1_rd1", 32'(bus0.mem_memread), 1);
    chk("t1_gnt", 32'(bus0.a_gnt), 1);
    chk("t1_addr", bus0.mem_addr, 32'h1004);
    chk("t1_wr", 32'(bus0.mem_memwrite), 0);
    step();
    chk("t1_rd2", 32'(bus0.mem_memread), 1);
    chk("t1_nodone", 32'(bus0.a_done), 0);
    step();
    chk("t1_done", 32'(bus0.a_done), 1);
    chk("t1_rdata", bus0.a_rdata, 32'hDEADBEEF);
    chk("t1_rd3", 32'(bus0.mem_memread), 0);
    chk("t1_bdone", 32'(bus0.b_done), 0);
    chk("t1_brdata", bus0.b_rdata, 0);
    bus0.a_req = 0;
    step();
    chk("t1_pulse", 32'(bus0.a_done), 0);
    chk("t1_idle", 32'(bus0.a_gnt), 0);
    step();
    chk("t1_norst", 32'(bus0.mem_memread), 0);

    // 2: B store
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 32'h1008;
    bus0.b_wdata = 32'h12345678; bus0.b_sign_mask = 4'b0100;
    bus0.mem_read_data = 32'hCAFEF00D;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t2_wr", 32'(bus0.mem_memwrite), 1);
      chk("t2_rd", 32'(bus0.mem_memread), 0);
      chk("t2_addr", bus0.mem_addr, 32'h1008);
      chk("t2_wdata", bus0.mem_write_data, 32'h12345678);
      chk("t2_mask", 32'(bus0.mem_sign_mask), 32'h4);
      chk("t2_gnt", 32'(bus0.b_gnt), 1);
      bus0.b_wdata = 32'h0;
      bus0.b_addr = 32'hFFFF;
    end
    step();
    chk("t2_done", 32'(bus0.b_done), 1);
    chk("t2_rdata", bus0.b_rdata, 0);
    chk("t2_wroff", 32'(bus0.mem_memwrite), 0);
    chk("t2_adone", 32'(bus0.a_done), 0);
    bus0.b_req = 0; bus0.b_we = 0;
    step();

    // 3: round-robin tie, both held
    bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 32'h100;
    bus0.b_req = 1; bus0.b_we = 0; bus0.b_addr = 32'h200;
    bus0.mem_read_data = 32'h0000_5A5A;
    for (int i = 0; i < 4; i++) begin
      logic ea;
      ea = (i % 2) == 0;
      step();
      chk("t3_agnt", 32'(bus0.a_gnt), 32'(ea));
      chk("t3_bgnt", 32'(bus0.b_gnt), 32'(!ea));
      chk("t3_addr", bus0.mem_addr,
          ea ? 32'h100 : 32'h200);
      step();
      step();
      chk("t3_adone", 32'(bus0.a_done), 32'(ea));
      chk("t3_bdone", 32'(bus0.b_done), 32'(!ea));
      chk("t3_rdata", ea ? bus0.a_rdata : bus0.b_rdata,
          32'h0000_5A5A);
      if (i == 3) begin
        bus0.a_req = 0;
        bus0.b_req = 0;
      end
      step();
    end
    step();
    chk("t3_quiet", 32'(bus0.a_gnt | bus0.b_gnt), 0);

    // 4: fixed priority, A wins every tie
    bus1.a_req = 1; bus1.b_req = 1;
    bus1.a_addr = 32'h300; bus1.b_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_agnt", 32'(bus1.a_gnt), 1);
      chk("t4_bgnt", 32'(bus1.b_gnt), 0);
      step();
      step();
      chk("t4_adone", 32'(bus1.a_done), 1);
      if (i == 2) bus1.a_req = 0;
      step();
    end
    step();
    chk("t4_bgnt2", 32'(bus1.b_gnt), 1);
    chk("t4_baddr", bus1.mem_addr, 32'h400);
    step();
    step();
    chk("t4_bdone", 32'(bus1.b_done), 1);
    bus1.b_req = 0;
    step();

    // 5: reset in second access cycle
    bus0.a_req = 1; bus0.a_we = 1; bus0.a_addr = 32'h500;
    bus0.a_wdata = 32'hA5A5A5A5;
    step();
    step();
    chk("t5_wr", 32'(bus0.mem_memwrite), 1);
    #1 reset = 1;
    #1;
    chk("t5_wroff", 32'(bus0.mem_memwrite), 0);
    chk("t5_gnt", 32'(bus0.a_gnt), 0);
    step();
    chk("t5_nodone", 32'(bus0.a_done), 0);
    chk("t5_wr2", 32'(bus0.mem_memwrite), 0);
    bus0.a_we = 0; bus0.b_req = 1;
    reset = 0;
    step();
    chk("t5_tieA", 32'(bus0.a_gnt), 1);
    chk("t5_tieB", 32'(bus0.b_gnt), 0);
    step();
    step();
    chk("t5_adone", 32'(bus0.a_done), 1);
    bus0.a_req = 0;
    step();
    step();
    chk("t5_bgnt", 32'(bus0.b_gnt), 1);
    step();
    step();
    chk("t5_bdone", 32'(bus0.b_done), 1);
    bus0.b_req = 0;
    step();

    // 6: A drops mid-access, B arrives mid-access
    bus0.a_req = 1; bus0.a_addr = 32'h600;
    bus0.b_addr = 32'h700;
    bus0.mem_read_data = 32'h1111_2222;
    step();
    bus0.a_req = 0; bus0.b_req = 1;
    step();
    step();
    chk("t6_adone", 32'(bus0.a_done), 1);
    chk("t6_ardata", bus0.a_rdata, 32'h1111_2222);
    step();
    chk("t6_idle", 32'(bus0.a_gnt | bus0.a_done), 0);
    step();
    chk("t6_bgnt", 32'(bus0.b_gnt), 1);
    chk("t6_agnt", 32'(bus0.a_gnt), 0);
    chk("t6_baddr", bus0.mem_addr, 32'h700);
    step();
    step();
    chk("t6_bdone", 32'(bus0.b_done), 1);
    chk("t6_nodup", 32'(bus0.a_done), 0);
    bus0.b_req = 0;
    step();
    step();
    chk("t6_end", 32'(bus0.a_gnt | bus0.b_gnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
